pdp8_dbreak: RTL

- Parametrised three-cycle data-break (DMA) engine; successor to the fixed RF-style controller.
- Programmed through PDP-8 IOTs on the standard io_* bus.
- Runs WC/CA/data break cycles on the ram_* handshake.
- Moves words between memory and a FIFO-buffered peripheral word stream, in either direction, with configurable device code, WC/CA locations, FIFO depth and field width.

---
 rtl/pdp8_dbreak.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pdp8_dbreak.sv
// pdp8_dbreak: three-cycle data-break (DMA) engine for a PDP-8 style CPU.
//
// Handshake rules, shared by both word streams and by the memory port:
//   - Peripheral streams: a word moves on a rising clk edge where valid and
//     ready are both 1. Valid and data hold steady until that edge.
//   - Memory port: ram_read_req/ram_write_req stays high, with ram_ma and
//     ram_out steady, until ram_done is seen high at a rising clk edge.
//     Read data is captured on that edge. The request then drops for at
//     least one cycle. Read and write are never high together.
//
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   iot, state, mb,          CPU IOT bus: instruction in progress, major
//   io_select, io_data_in    state phase, instruction word, device code, AC
//   io_data_out/_avail       device-to-AC data and its valid flag
//   io_interrupt, io_skip    interrupt request, skip request
//   ram_*                    memory request/handshake, address and data
//   dev_in_*                 peripheral words going to memory (d->m)
//   dev_out_*                memory words going to the peripheral (m->d)
//   busy                     transfer active
//   o_dbg_state              current break-cycle FSM state (debug)
module pdp8_dbreak #(
  parameter logic [5:0]  DEV_BASE   = 6'o60,
  parameter logic [11:0] WC_ADDR    = 12'o7750,
  parameter int          FIFO_DEPTH = 4,
  parameter int          FIELD_W    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iot,
  input  logic [3:0]           state,
  input  logic [11:0]          mb,
  input  logic [5:0]           io_select,
  input  logic [11:0]          io_data_in,
  output logic [11:0]          io_data_out,
  output logic                 io_data_avail,
  output logic                 io_interrupt,
  output logic                 io_skip,
  output logic                 ram_read_req,
  output logic                 ram_write_req,
  input  logic                 ram_done,
  output logic [11+FIELD_W:0]  ram_ma,
  input  logic [11:0]          ram_in,
  output logic [11:0]          ram_out,
  input  logic                 dev_in_valid,
  input  logic [11:0]          dev_in_data,
  output logic                 dev_in_ready,
  output logic                 dev_out_valid,
  output logic [11:0]          dev_out_data,
  input  logic                 dev_out_ready,
  output logic                 busy,
  output logic [2:0]           o_dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [11:0]   CA_ADDR  = WC_ADDR + 12'd1;
  localparam logic [5:0]    DEV_1    = DEV_BASE + 6'd1;
  localparam logic [5:0]    DEV_2    = DEV_BASE + 6'd2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WC_RD = 3'd1;
  localparam logic [2:0] S_WC_WR = 3'd2;
  localparam logic [2:0] S_CA_RD = 3'd3;
  localparam logic [2:0] S_CA_WR = 3'd4;
  localparam logic [2:0] S_DATA  = 3'd5;
  localparam logic [2:0] S_CHECK = 3'd6;

  logic [3:0]          r_prev_state;
  logic                r_done, r_ie, r_err, r_dir, r_busy, r_abort, r_req;
  logic [FIELD_W-1:0]  r_field;
  logic [2:0]          r_state;
  logic [11:0]         r_wc, r_ca;
  logic [11:0]         r_fifo [FIFO_DEPTH];
  logic [AW-1:0]       r_wp, r_rp;
  logic [AW:0]         r_cnt;

  logic        w_fire, w_sel0, w_sel1, w_sel2, w_clr;
  logic [2:0]  w_op;
  logic        w_full, w_empty, w_ready, w_hs, w_data_hs, w_push, w_pop;
  logic [11:0] w_field_ext, w_status, w_fifo_head, w_push_data;
  logic [2:0]  w_next;
  logic        w_unused;

  // Opcode bits and the unused high AC bits are not needed by this device.
  assign w_unused = ^{mb[11:3], io_data_in};

  assign w_op   = mb[2:0];
  assign w_sel0 = (io_select == DEV_BASE);
  assign w_sel1 = (io_select == DEV_1);
  assign w_sel2 = (io_select == DEV_2);
  // One action per IOT: only the first cycle of phase 1 counts.
  assign w_fire = iot && (state == 4'h1) && (r_prev_state != 4'h1);
  assign w_clr  = w_fire && w_sel0 && (w_op == 3'd1);

  assign w_full      = (r_cnt == CNT_FULL);
  assign w_empty     = (r_cnt == '0);
  assign w_fifo_head = r_fifo[r_rp];
  // Data side can make progress: d->m needs a word, m->d needs space.
  assign w_ready     = r_dir ? !w_full : !w_empty;

  assign w_hs      = r_req && ram_done;
  assign w_data_hs = (r_state == S_DATA) && w_hs && !r_abort && !w_clr;

  assign dev_in_ready  = r_busy && !r_abort && !r_dir && !w_full;
  assign dev_out_valid = r_dir && !w_empty;
  assign dev_out_data  = dev_out_valid ? w_fifo_head : 12'd0;

  assign w_push      = r_dir ? w_data_hs : (dev_in_valid && dev_in_ready);
  assign w_pop       = r_dir ? (dev_out_valid && dev_out_ready) : w_data_hs;
  assign w_push_data = r_dir ? ram_in : dev_in_data;

  assign w_field_ext = 12'(r_field);
  assign w_status    = {r_done, r_busy, r_err, 4'b0000, r_ie, r_dir, w_field_ext[2:0]};

  assign busy         = r_busy;
  assign io_interrupt = r_ie && (r_done || r_err);
  assign o_dbg_state  = r_state;

  always_comb begin
    io_data_out   = 12'd0;
    io_data_avail = 1'b0;
    io_skip       = 1'b0;
    if (iot && w_sel1 && (w_op == 3'd1)) io_skip = r_done;
    if (iot && w_sel1 && (w_op == 3'd2)) begin
      io_data_out   = w_status;
      io_data_avail = 1'b1;
    end
    if (iot && w_sel2 && (w_op == 3'd2)) begin
      io_data_out   = w_field_ext << 3;
      io_data_avail = 1'b1;
    end
  end

  always_comb begin
    ram_ma        = '0;
    ram_out       = 12'd0;
    ram_read_req  = 1'b0;
    ram_write_req = 1'b0;
    w_next        = S_IDLE;
    case (r_state)
      S_WC_RD: begin
        ram_ma       = {{FIELD_W{1'b0}}, WC_ADDR};
        ram_read_req = r_req;
        w_next       = S_WC_WR;
      end
      S_WC_WR: begin
        ram_ma        = {{FIELD_W{1'b0}}, WC_ADDR};
        ram_out       = r_wc;
        ram_write_req = r_req;
        w_next        = S_CA_RD;
      end
      S_CA_RD: begin
        ram_ma       = {{FIELD_W{1'b0}}, CA_ADDR};
        ram_read_req = r_req;
        w_next       = S_CA_WR;
      end
      S_CA_WR: begin
        ram_ma        = {{FIELD_W{1'b0}}, CA_ADDR};
        ram_out       = r_ca;
        ram_write_req = r_req;
        w_next        = S_DATA;
      end
      S_DATA: begin
        // r_ca already holds the incremented CA: this is the target word.
        ram_ma        = {r_field, r_ca};
        ram_out       = r_dir ? 12'd0 : w_fifo_head;
        ram_read_req  = r_req && r_dir;
        ram_write_req = r_req && !r_dir;
        w_next        = S_CHECK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_state <= 4'h0;
      r_done       <= 1'b0;
      r_ie         <= 1'b0;
      r_err        <= 1'b0;
      r_dir        <= 1'b0;
      r_busy       <= 1'b0;
      r_abort      <= 1'b0;
      r_req        <= 1'b0;
      r_field      <= '0;
      r_state      <= S_IDLE;
      r_wc         <= 12'd0;
      r_ca         <= 12'd0;
    end else begin
      r_prev_state <= state;

      if (w_fire && w_sel0) begin
        if (w_op == 3'd1) begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
        end else if ((w_op == 3'd3) || (w_op == 3'd5)) begin
          if (r_busy) begin
            r_err <= 1'b1;
          end else begin
            r_busy <= 1'b1;
            r_dir  <= w_op[2];
            r_done <= 1'b0;
          end
        end
      end
      if (w_fire && w_sel1 && (w_op == 3'd4)) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
      if (w_fire && w_sel2 && (w_op == 3'd1)) r_field <= io_data_in[FIELD_W+2:3];
      if (w_fire && w_sel2 && (w_op == 3'd4)) r_ie <= io_data_in[0];

      // Abort never cuts a memory handshake short: if a request is
      // outstanding, wait for its ram_done before returning to IDLE.
      if (w_clr && r_busy) begin
        if (!r_req || ram_done) begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_abort <= 1'b0;
        end else begin
          r_abort <= 1'b1;
        end
      end else if (r_abort) begin
        if (ram_done) begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_abort <= 1'b0;
        end
      end else begin
        case (r_state)
          S_IDLE: if (r_busy && w_ready) r_state <= S_WC_RD;
          S_WC_RD, S_WC_WR, S_CA_RD, S_CA_WR, S_DATA: begin
            // Entering a memory state leaves req low for one cycle, which
            // gives the mandatory gap between consecutive accesses.
            if (!r_req) begin
              r_req <= 1'b1;
            end else if (ram_done) begin
              r_req   <= 1'b0;
              r_state <= w_next;
              if (r_state == S_WC_RD) r_wc <= ram_in + 12'd1;
              if (r_state == S_CA_RD) r_ca <= ram_in + 12'd1;
            end
          end
          S_CHECK: begin
            if (r_wc == 12'd0) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else if (w_ready) begin
              r_state <= S_WC_RD;
            end else begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // FIFO pointers/count; clear wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (w_clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PTR_ONE;
      if (w_pop)  r_rp <= r_rp + PTR_ONE;
      if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_ONE;
      else if (w_pop && !w_push) r_cnt <= r_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !w_clr) r_fifo[r_wp] <= w_push_data;
  end

endmodule
